// File: rtl/max_arb.sv
// max_arb: line-granular round-robin arbiter between two pixel requesters
// feeding one shared max-of-channels datapath. A LAT-deep tag pipeline
// follows each accepted beat through the datapath so the result can be
// routed back to the requester that produced it. A sticky err flag
// reports any cycle where a returning result has no matching tag.
// Optional macro MAX_ARB_FIXED_PRIO_EN: when defined, s0 always wins a tie
// in IDLE and the round-robin pointer is ignored.
module max_arb #(
    parameter int W   = 24,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s0_valid,
    input  logic [W-1:0] s0_data,
    input  logic         s0_last,
    output logic         s0_ready,
    input  logic         s1_valid,
    input  logic [W-1:0] s1_data,
    input  logic         s1_last,
    output logic         s1_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    output logic         m_last,
    input  logic         r_valid,
    input  logic [7:0]   r_data,
    input  logic [1:0]   r_index,
    input  logic         r_last,
    output logic         d0_valid,
    output logic         d1_valid,
    output logic [7:0]   d_data,
    output logic [1:0]   d_index,
    output logic         d_last,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t         state;
    logic           last_served;
    logic           tie_pick1;
    logic           grant0;
    logic           grant1;
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;
    logic           tag_v_out;
    logic           tag_id_out;

`ifdef MAX_ARB_FIXED_PRIO_EN
    assign tie_pick1 = 1'b0;
`else
    assign tie_pick1 = ~last_served;
`endif

    // Grant FSM: a grant lasts one whole line, then one IDLE cycle follows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid && s1_valid) begin
                        state <= tie_pick1 ? GNT1 : GNT0;
                    end else if (s0_valid) begin
                        state <= GNT0;
                    end else if (s1_valid) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (s0_valid && s0_last) begin
                        state       <= IDLE;
                        last_served <= 1'b0;
                    end
                end
                GNT1: begin
                    if (s1_valid && s1_last) begin
                        state       <= IDLE;
                        last_served <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant0   = (state == GNT0);
    assign grant1   = (state == GNT1);
    assign s0_ready = grant0;
    assign s1_ready = grant1;

    // Forward the granted requester to the shared datapath; zeros when idle
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        if (grant0) begin
            m_valid = s0_valid;
            m_data  = s0_data;
            m_last  = s0_last;
        end else if (grant1) begin
            m_valid = s1_valid;
            m_data  = s1_data;
            m_last  = s1_last;
        end
    end

    // Tag pipeline tracks {valid, requester id} alongside the datapath latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= m_valid;
            tag_id[0] <= grant1;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign tag_v_out  = tag_v[LAT-1];
    assign tag_id_out = tag_id[LAT-1];

    // Results are only routed when a live tag backs them up, so anything
    // still in flight across a reset is discarded rather than misdelivered.
    assign d0_valid = r_valid & tag_v_out & ~tag_id_out;
    assign d1_valid = r_valid & tag_v_out &  tag_id_out;
    assign d_data   = rst_n ? r_data  : 8'd0;
    assign d_index  = rst_n ? r_index : 2'd0;
    assign d_last   = rst_n ? r_last  : 1'b0;

    // Sticky error whenever a returning result disagrees with the tag valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (r_valid != tag_v_out) begin
            err <= 1'b1;
        end
    end

endmodule
